// File: rtl/i2s_rx_deserializer_if.sv
// Parallel word port of the I2S receive deserializer toward the RX buffer writer.
//   data_out - received word, right-aligned, upper bits zero
//   lr       - channel of data_out (0 = left, 1 = right)
//   valid    - data_out/lr hold a word
//   ready    - downstream accepts the word
interface i2s_rx_deserializer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data_out;
  logic             lr;
  logic             valid;
  logic             ready;

  // Deserializer side drives the word, buffer writer side answers with ready
  modport master (output data_out, output lr, output valid, input ready);
  modport slave  (input data_out, input lr, input valid, output ready);
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: samples ws/sd on posedge sclk, finds word-select
// edges, assembles 16- or 32-bit words in Philips or MSB-justified framing and
// presents them with their channel on a valid/ready port. Overrun and framing
// errors are kept as sticky flags.
//   sclk      - serial bit clock, sole clock
//   rst       - synchronous reset, active-high
//   en        - capture enable
//   philips   - 1 = MSB one sclk after the WS edge, 0 = MSB in the WS-edge cycle
//   frame16   - 1 = 16-bit words, 0 = 32-bit words
//   ws, sd    - word select (0 = left) and serial data, MSB first
//   clear_err - single-cycle clear of the sticky flags
//   overrun   - sticky: a completed word was dropped
//   frame_err - sticky: WS toggled mid-word
//   out_if    - data_out / lr / valid / ready word port
// WIDTH must be at least 32.
module i2s_rx_deserializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  philips,
  input  logic                  frame16,
  input  logic                  ws,
  input  logic                  sd,
  input  logic                  clear_err,
  output logic                  overrun,
  output logic                  frame_err,
  i2s_rx_deserializer_if.master out_if
);

  localparam int unsigned SH_W  = 31;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ws_q, ws_d;
  logic             primed_q, primed_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lr_cap_q, lr_cap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             lr_q, lr_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             edge_c;
  logic [31:0]      word_c;
  logic [CNT_W-1:0] cnt_load_c;
  logic             done_c;
  logic             fe_set_c;
  logic             ov_set_c;

  // WS edge only counts once ws_q holds a real previous sample
  assign edge_c     = primed_q & (ws ^ ws_q);
  // Word including this cycle's bit; the low maxp+1 bits form a completed word
  assign word_c     = {sh_q, sd};
  // Bits still to shift after the MSB: maxp - 1
  assign cnt_load_c = frame16 ? CNT_W'(14) : CNT_W'(30);

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    ws_d        = ws;
    primed_d    = en;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    lr_cap_d    = lr_cap_q;
    data_d      = data_q;
    lr_d        = lr_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    done_c      = 1'b0;
    fe_set_c    = 1'b0;
    ov_set_c    = 1'b0;

    if (!en) begin
      // Partial word is dropped; held word and flags stay
      state_d = ST_IDLE;
      sh_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          if (edge_c) begin
            lr_cap_d = ws;
            if (philips) begin
              state_d = ST_DELAY;
            end else begin
              sh_d    = SH_W'(sd);
              cnt_d   = cnt_load_c;
              state_d = ST_SHIFT;
            end
          end
        end

        ST_DELAY: begin
          if (edge_c) begin
            // WS moved again before the MSB: restart the delay slot
            fe_set_c = 1'b1;
            lr_cap_d = ws;
          end else begin
            sh_d    = SH_W'(sd);
            cnt_d   = cnt_load_c;
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          sh_d  = word_c[SH_W-1:0];
          cnt_d = cnt_q - CNT_W'(1);
          if (edge_c) begin
            lr_cap_d = ws;
            // Only a Philips edge on the LSB cycle is a legal slot boundary
            if (philips && (cnt_q == '0)) begin
              done_c = 1'b1;
            end else begin
              fe_set_c = 1'b1;
            end
            if (philips) begin
              state_d = ST_DELAY;
            end else begin
              sh_d  = SH_W'(sd);
              cnt_d = cnt_load_c;
            end
          end else if (cnt_q == '0) begin
            done_c  = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Handshake: an accepted word frees the register, a completion may refill it
    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end
    if (done_c) begin
      if (!valid_q || out_if.ready) begin
        data_d  = frame16 ? WIDTH'(word_c[15:0]) : WIDTH'(word_c);
        lr_d    = lr_cap_q;
        valid_d = 1'b1;
      end else begin
        ov_set_c = 1'b1;
      end
    end

    // Sticky flags: a set in the clear cycle wins
    overrun_d   = (overrun_q & ~clear_err) | ov_set_c;
    frame_err_d = (frame_err_q & ~clear_err) | fe_set_c;
  end

  // State and output registers
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ws_q        <= 1'b0;
      primed_q    <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      lr_cap_q    <= 1'b0;
      data_q      <= '0;
      lr_q        <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      primed_q    <= primed_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      lr_cap_q    <= lr_cap_d;
      data_q      <= data_d;
      lr_q        <= lr_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_if.data_out = data_q;
  assign out_if.lr       = lr_q;
  assign out_if.valid    = valid_q;
  assign overrun         = overrun_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: directed framing scenarios plus randomized
// slots, ready, clear_err and en, checked every cycle against a frame-level
// model that derives words and errors from the spacing of WS edges.
module tb_i2s_rx_deserializer;

  localparam int unsigned WIDTH = 32;
  localparam int MAXC = 32768;
  localparam int MAXS = 4096;

  logic sclk      = 1'b0;
  logic rst       = 1'b1;
  logic en        = 1'b0;
  logic philips   = 1'b0;
  logic frame16   = 1'b0;
  logic ws        = 1'b0;
  logic sd        = 1'b0;
  logic clear_err = 1'b0;
  logic overrun;
  logic frame_err;

  i2s_rx_deserializer_if #(.WIDTH(WIDTH)) bus ();

  i2s_rx_deserializer #(.WIDTH(WIDTH)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .en        (en),
    .philips   (philips),
    .frame16   (frame16),
    .ws        (ws),
    .sd        (sd),
    .clear_err (clear_err),
    .overrun   (overrun),
    .frame_err (frame_err),
    .out_if    (bus)
  );

  always #5 sclk = ~sclk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  int          cyc       = 0;
  int          run_start = -1;
  int          last_edge = -1;
  bit          ws_hist [MAXC];
  bit          sd_hist [MAXC];
  logic [31:0] m_data  = '0;
  logic        m_lr    = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ov    = 1'b0;
  logic        m_fe    = 1'b0;
  logic [32:0] model_words [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Words complete a fixed distance after the most recent WS edge; an edge
  // closer than one word length to the previous one is a framing error.
  always @(posedge sclk) begin : model
    int          wlen;
    int          st;
    bit          comp;
    bit          is_edge;
    bit          fe_s;
    bit          ov_s;
    logic        wlr;
    logic [31:0] w;
    ws_hist[cyc] = ws;
    sd_hist[cyc] = sd;
    comp = 0; fe_s = 0; ov_s = 0; wlr = 0; w = '0; st = 0;
    if (rst) begin
      m_data = '0; m_lr = 0; m_valid = 0; m_ov = 0; m_fe = 0;
      run_start = -1; last_edge = -1;
    end else begin
      wlen = frame16 ? 16 : 32;
      if (!en) begin
        run_start = -1; last_edge = -1;
      end else if (run_start < 0) begin
        run_start = cyc;
      end else begin
        is_edge = (ws != ws_hist[cyc-1]);
        if (philips) begin
          if (last_edge >= 0 && cyc == last_edge + wlen) begin
            comp = 1; st = last_edge + 1; wlr = ws_hist[last_edge];
          end
          if (is_edge) begin
            if (last_edge >= 0 && cyc < last_edge + wlen) fe_s = 1;
            last_edge = cyc;
          end
        end else begin
          if (is_edge) begin
            if (last_edge >= 0 && cyc < last_edge + wlen) fe_s = 1;
            last_edge = cyc;
          end
          if (last_edge >= 0 && cyc == last_edge + wlen - 1) begin
            comp = 1; st = last_edge; wlr = ws_hist[last_edge];
          end
        end
        if (comp) for (int k = st; k <= cyc; k++) w = {w[30:0], sd_hist[k]};
      end
      if (comp) begin
        if (!m_valid || bus.ready) begin
          m_data = w; m_lr = wlr; m_valid = 1;
          model_words.push_back({wlr, w});
        end else begin
          ov_s = 1;
        end
      end else if (m_valid && bus.ready) begin
        m_valid = 0;
      end
      m_ov = (m_ov && !clear_err) || ov_s;
      m_fe = (m_fe && !clear_err) || fe_s;
    end
    cyc++;
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge sclk) begin
    check("data_out",  64'(bus.data_out), 64'(m_data));
    check("lr",        64'(bus.lr),       64'(m_lr));
    check("valid",     64'(bus.valid),    64'(m_valid));
    check("overrun",   64'(overrun),      64'(m_ov));
    check("frame_err", 64'(frame_err),    64'(m_fe));
  end

  // ---------------- stimulus ----------------
  bit s_ws [MAXS];
  bit s_sd [MAXS];
  int s_len     = 0;
  bit rand_mode = 0;

  function automatic void stim_clear();
    s_len = 0;
    for (int i = 0; i < MAXS; i++) s_sd[i] = 1'($urandom);
  endfunction

  function automatic void add_cycles(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      s_ws[s_len] = lvl;
      s_len++;
    end
  endfunction

  // One WS slot of 'half' cycles; the word's bits start at the slot edge
  // (MSB-justified) or one cycle later (Philips)
  function automatic void add_slot(input bit lvl, input logic [31:0] word,
                                   input int wbits, input int half, input bit ph);
    int base = s_len;
    int nb   = (half < wbits) ? half : wbits;
    add_cycles(lvl, half);
    for (int b = 0; b < nb; b++) s_sd[base + b + int'(ph)] = word[wbits-1-b];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      ws = s_ws[i];
      sd = s_sd[i];
      if (rand_mode) begin
        bus.ready = ($urandom_range(0, 3) != 0);
        clear_err = ($urandom_range(0, 40) == 0);
        en        = ($urandom_range(0, 250) != 0);
      end
      @(negedge sclk);
    end
    clear_err = 1'b0;
  endtask

  task automatic set_mode(input bit ph, input bit f16);
    en        = 1'b0;
    bus.ready = 1'b1;
    clear_err = 1'b0;
    step(2);
    philips = ph;
    frame16 = f16;
    step(1);
  endtask

  function automatic logic [32:0] get_word(input int i);
    if (i < model_words.size()) return model_words[i];
    return 33'h0;
  endfunction

  initial begin
    bus.ready = 1'b1;
    step(3);
    check("rst_data",      64'(bus.data_out), 64'h0);
    check("rst_lr",        64'(bus.lr),       64'h0);
    check("rst_valid",     64'(bus.valid),    64'h0);
    check("rst_overrun",   64'(overrun),      64'h0);
    check("rst_frame_err", 64'(frame_err),    64'h0);
    rst = 1'b0;

    // MSB-justified 32-bit back-to-back slots
    set_mode(1'b0, 1'b0);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, 32'hDEADBEEF, 32, 32, 1'b0);
    add_slot(1'b1, 32'h12345678, 32, 32, 1'b0);
    add_cycles(1'b1, 3);
    model_words.delete();
    en = 1'b1;
    play(s_len);
    check("t1_count", 64'(model_words.size()), 64'd2);
    check("t1_w0", 64'(get_word(0)), {31'h0, 1'b0, 32'hDEADBEEF});
    check("t1_w1", 64'(get_word(1)), {31'h0, 1'b1, 32'h12345678});
    check("t1_valid_idle", 64'(bus.valid), 64'h0);
    check("t1_flags", 64'({overrun, frame_err}), 64'h0);

    // Philips 16-bit, edge on the LSB cycle is legal
    set_mode(1'b1, 1'b1);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, 32'h0000A5C3, 16, 16, 1'b1);
    add_slot(1'b1, 32'h00003C5A, 16, 16, 1'b1);
    add_cycles(1'b1, 4);
    model_words.delete();
    en = 1'b1;
    play(s_len);
    check("t2_w0", 64'(get_word(0)), {31'h0, 1'b0, 32'h0000A5C3});
    check("t2_w1", 64'(get_word(1)), {31'h0, 1'b1, 32'h00003C5A});
    check("t2_frame_err", 64'(frame_err), 64'h0);

    // ready held low across two words: overrun, first word retained
    set_mode(1'b0, 1'b0);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, 32'h11111111, 32, 32, 1'b0);
    add_slot(1'b1, 32'h22222222, 32, 32, 1'b0);
    add_cycles(1'b1, 3);
    model_words.delete();
    bus.ready = 1'b0;
    en = 1'b1;
    play(s_len);
    check("t3_count", 64'(model_words.size()), 64'd1);
    check("t3_valid", 64'(bus.valid), 64'h1);
    check("t3_data", 64'(bus.data_out), 64'h11111111);
    check("t3_overrun", 64'(overrun), 64'h1);
    bus.ready = 1'b1;
    step(1);
    check("t3_valid_cleared", 64'(bus.valid), 64'h0);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("t3_overrun_cleared", 64'(overrun), 64'h0);

    // Philips 32-bit, WS toggles after 10 data bits
    set_mode(1'b1, 1'b0);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, $urandom, 32, 11, 1'b1);
    add_slot(1'b1, 32'hCAFEF00D, 32, 32, 1'b1);
    add_cycles(1'b1, 4);
    model_words.delete();
    en = 1'b1;
    play(s_len);
    check("t4_frame_err", 64'(frame_err), 64'h1);
    check("t4_count", 64'(model_words.size()), 64'd1);
    check("t4_w0", 64'(get_word(0)), {31'h0, 1'b1, 32'hCAFEF00D});
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("t4_fe_cleared", 64'(frame_err), 64'h0);

    // Reset at bit 20 of a word while a word is held
    set_mode(1'b0, 1'b0);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, 32'h13579BDF, 32, 32, 1'b0);
    add_slot(1'b1, 32'h2468ACE0, 32, 32, 1'b0);
    bus.ready = 1'b0;
    en = 1'b1;
    play(55);
    check("t5_valid_before", 64'(bus.valid), 64'h1);
    ws  = s_ws[55];
    sd  = s_sd[55];
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_rst_data",  64'(bus.data_out), 64'h0);
    check("t5_rst_valid", 64'(bus.valid),    64'h0);
    check("t5_rst_lr",    64'(bus.lr),       64'h0);
    check("t5_rst_flags", 64'({overrun, frame_err}), 64'h0);
    model_words.delete();
    ws = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom);
      step(1);
    end
    check("t5_no_word", 64'(model_words.size()), 64'd0);
    check("t5_valid_quiet", 64'(bus.valid), 64'h0);
    bus.ready = 1'b1;
    stim_clear();
    add_cycles(1'b1, 2);
    add_slot(1'b0, 32'h0F1E2D3C, 32, 32, 1'b0);
    add_cycles(1'b0, 3);
    play(s_len);
    check("t5_w0", 64'(get_word(0)), {31'h0, 1'b0, 32'h0F1E2D3C});

    // 16-bit MSB-justified word in a 32-cycle slot, trailing junk ignored
    set_mode(1'b0, 1'b1);
    stim_clear();
    add_cycles(1'b1, 3);
    add_slot(1'b0, 32'hBEEFFFFF, 32, 32, 1'b0);
    add_cycles(1'b0, 3);
    model_words.delete();
    en = 1'b1;
    play(s_len);
    check("t6_count", 64'(model_words.size()), 64'd1);
    check("t6_w0", 64'(get_word(0)), {31'h0, 1'b0, 32'h0000BEEF});
    check("t6_flags", 64'({overrun, frame_err}), 64'h0);

    // Randomized framing, handshake, clears and enable drops
    for (int r = 0; r < 10; r++) begin
      bit ph;
      bit f16;
      bit lvl;
      int wb;
      int half;
      int sel;
      ph  = 1'($urandom);
      f16 = 1'($urandom);
      wb  = f16 ? 16 : 32;
      set_mode(ph, f16);
      stim_clear();
      lvl = 1'($urandom);
      add_cycles(~lvl, 2 + $urandom_range(0, 3));
      for (int s = 0; s < 12; s++) begin
        sel = $urandom_range(0, 9);
        if (sel < 5)      half = wb;
        else if (sel < 8) half = wb + $urandom_range(1, 8);
        else              half = $urandom_range(2, wb - 1);
        add_slot(lvl, $urandom, wb, half, ph);
        lvl = ~lvl;
      end
      add_cycles(~lvl, 4);
      en = 1'b1;
      rand_mode = 1'b1;
      play(s_len);
      rand_mode = 1'b0;
    end
    set_mode(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
